// File: rtl/i2c_xlate_arbiter.sv
// Round-robin arbiter that shares one I2C master byte engine between NREQ requesters,
// remapping one virtual target address and enforcing a watchdog on each transaction.
module i2c_xlate_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [7*NREQ-1:0] req_addr,
    input  logic [NREQ-1:0]   req_rw,
    input  logic [8*NREQ-1:0] req_wdata,
    output logic [NREQ-1:0]   req_gnt,
    output logic [NREQ-1:0]   req_done,
    output logic [7:0]        req_rdata,
    output logic              req_nack,
    output logic              req_timeout,
    input  logic              xlate_en,
    input  logic [6:0]        xlate_from,
    input  logic [6:0]        xlate_to,
    output logic              m_cmd_valid,
    input  logic              m_cmd_ready,
    output logic [6:0]        m_cmd_addr,
    output logic              m_cmd_rw,
    output logic [7:0]        m_cmd_wdata,
    input  logic              m_rsp_valid,
    input  logic [7:0]        m_rsp_rdata,
    input  logic              m_rsp_nack,
    output logic              m_abort,
    output logic              busy
);

    localparam int IW = $clog2(NREQ);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    state_t state, state_next;

    logic [IW-1:0]   rr, owner, pick;
    logic            pick_valid;
    logic [IW:0]     scan;
    logic [TW-1:0]   timer;
    logic            expired;
    logic [NREQ-1:0] owner_oh;

    logic [6:0] addr_arr  [NREQ];
    logic [7:0] wdata_arr [NREQ];

    logic [6:0] addr_q;
    logic       rw_q;
    logic [7:0] wdata_q;
    logic [7:0] rdata_q;
    logic       nack_q;
    logic       timeout_q;

    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            addr_arr[i]  = req_addr[7*i +: 7];
            wdata_arr[i] = req_wdata[8*i +: 8];
        end
    end

    // First pending requester found scanning rr, rr+1, ... with wrap at NREQ.
    always_comb begin
        pick       = '0;
        pick_valid = 1'b0;
        scan       = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            scan = {1'b0, rr} + (IW+1)'(i);
            if (scan >= (IW+1)'(NREQ))
                scan = scan - (IW+1)'(NREQ);
            if (!pick_valid && req_valid[IW'(scan)]) begin
                pick_valid = 1'b1;
                pick       = IW'(scan);
            end
        end
    end

    always_comb begin
        owner_oh = NREQ'(1) << owner;
    end

    // Timer compares with >= so a handshake landing exactly on expiry still
    // leaves the following WAIT cycle able to expire.
    always_comb begin
        state_next  = state;
        expired     = 1'b0;
        m_abort     = 1'b0;
        m_cmd_valid = 1'b0;
        req_gnt     = '0;
        req_done    = '0;
        req_rdata   = '0;
        req_nack    = 1'b0;
        req_timeout = 1'b0;
        busy        = (state != IDLE);
        case (state)
            IDLE: begin
                if (pick_valid)
                    state_next = ISSUE;
            end
            ISSUE: begin
                m_cmd_valid = 1'b1;
                req_gnt     = owner_oh;
                if (m_cmd_ready) begin
                    state_next = WAIT;
                end else if (timer >= TW'(TIMEOUT - 1)) begin
                    expired    = 1'b1;
                    m_abort    = 1'b1;
                    state_next = DONE;
                end
            end
            WAIT: begin
                req_gnt = owner_oh;
                if (m_rsp_valid) begin
                    state_next = DONE;
                end else if (timer >= TW'(TIMEOUT - 1)) begin
                    expired    = 1'b1;
                    m_abort    = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                req_gnt     = owner_oh;
                req_done    = owner_oh;
                req_rdata   = rdata_q;
                req_nack    = nack_q;
                req_timeout = timeout_q;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rr        <= '0;
            owner     <= '0;
            timer     <= '0;
            addr_q    <= '0;
            rw_q      <= 1'b0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            nack_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        owner   <= pick;
                        addr_q  <= (xlate_en && addr_arr[pick] == xlate_from) ? xlate_to : addr_arr[pick];
                        rw_q    <= req_rw[pick];
                        wdata_q <= wdata_arr[pick];
                        timer   <= '0;
                    end
                end
                ISSUE, WAIT: begin
                    timer <= timer + 1'b1;
                    if (state == WAIT && m_rsp_valid) begin
                        rdata_q   <= rw_q ? m_rsp_rdata : 8'h00;
                        nack_q    <= m_rsp_nack;
                        timeout_q <= 1'b0;
                    end else if (expired) begin
                        rdata_q   <= 8'h00;
                        nack_q    <= 1'b0;
                        timeout_q <= 1'b1;
                    end
                end
                DONE: begin
                    rr <= (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign m_cmd_addr  = addr_q;
    assign m_cmd_rw    = rw_q;
    assign m_cmd_wdata = wdata_q;

endmodule

// File: tb/tb_i2c_xlate_arbiter.sv
// Randomized bench for i2c_xlate_arbiter: a transaction-level reference model predicts
// owner, translated command, abort timing and completion results.
module tb_i2c_xlate_arbiter;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [7*NREQ-1:0] req_addr = '0;
    logic [NREQ-1:0]   req_rw = '0;
    logic [8*NREQ-1:0] req_wdata = '0;
    logic [NREQ-1:0]   req_gnt, req_done;
    logic [7:0]        req_rdata;
    logic              req_nack, req_timeout;
    logic              xlate_en = 1'b0;
    logic [6:0]        xlate_from = '0, xlate_to = '0;
    logic              m_cmd_valid;
    logic              m_cmd_ready = 1'b0;
    logic [6:0]        m_cmd_addr;
    logic              m_cmd_rw;
    logic [7:0]        m_cmd_wdata;
    logic              m_rsp_valid = 1'b0;
    logic [7:0]        m_rsp_rdata = '0;
    logic              m_rsp_nack = 1'b0;
    logic              m_abort, busy;

    int n_checks = 0;
    int n_bad    = 0;

    logic [6:0]      d_addr  [NREQ];
    logic            d_rw    [NREQ];
    logic [7:0]      d_wdata [NREQ];
    logic [NREQ-1:0] pending = '0;
    logic [NREQ-1:0] dropped = '0;
    int              rr_m    = 0;

    i2c_xlate_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_rw(req_rw), .req_wdata(req_wdata),
        .req_gnt(req_gnt), .req_done(req_done), .req_rdata(req_rdata),
        .req_nack(req_nack), .req_timeout(req_timeout),
        .xlate_en(xlate_en), .xlate_from(xlate_from), .xlate_to(xlate_to),
        .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready), .m_cmd_addr(m_cmd_addr),
        .m_cmd_rw(m_cmd_rw), .m_cmd_wdata(m_cmd_wdata),
        .m_rsp_valid(m_rsp_valid), .m_rsp_rdata(m_rsp_rdata), .m_rsp_nack(m_rsp_nack),
        .m_abort(m_abort), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL sim_time_limit: got expired want finished");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    function automatic int rr_pick(input logic [NREQ-1:0] m, input int start);
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = (start + k) % NREQ;
            if (m[j]) return j;
        end
        return -1;
    endfunction

    function automatic logic [6:0] xl(input logic [6:0] a);
        return (xlate_en && a == xlate_from) ? xlate_to : a;
    endfunction

    task automatic drive_reqs();
        for (int i = 0; i < NREQ; i++) begin
            req_addr[7*i +: 7]  = d_addr[i];
            req_rw[i]           = d_rw[i];
            req_wdata[8*i +: 8] = d_wdata[i];
        end
        req_valid = pending & ~dropped;
    endtask

    task automatic set_desc(input int i, input logic [6:0] a, input logic rw, input logic [7:0] wd);
        pending[i] = 1'b1;
        d_addr[i]  = a;
        d_rw[i]    = rw;
        d_wdata[i] = wd;
    endtask

    // Entered at a negedge with the arbiter idle and requester inputs final.
    // d1: cycles the engine stalls before ready; d2: extra cycles before response.
    task automatic run_txn(input int d1, input int d2, input logic [7:0] rd, input logic nk);
        int own, t, rsp_t;
        logic accepted, finished, hs, rsp, ab;
        logic [6:0] ea;
        logic erw;
        logic [7:0] ew;
        logic [NREQ-1:0] oh;
        drive_reqs();
        own = rr_pick(pending, rr_m);
        if (own < 0) begin
            step();
            #1;
            chk("idle_busy", busy, 0);
            chk("idle_gnt", req_gnt, 0);
            return;
        end
        ea    = xl(d_addr[own]);
        erw   = d_rw[own];
        ew    = d_wdata[own];
        oh    = NREQ'(1) << own;
        rsp_t = d1 + 1 + d2;
        step();
        t = 0; accepted = 0; finished = 0; ab = 0;
        while (!finished) begin
            hs  = !accepted && (t == d1);
            rsp = accepted && (t == rsp_t);
            m_cmd_ready = hs || (accepted && $urandom_range(0, 1) == 1);
            m_rsp_valid = rsp || (!accepted && $urandom_range(0, 3) == 0);
            m_rsp_rdata = rsp ? rd : 8'($urandom);
            m_rsp_nack  = rsp ? nk : 1'($urandom);
            if (accepted) begin
                xlate_en   = 1'($urandom);
                xlate_from = 7'($urandom);
                xlate_to   = 7'($urandom);
                if ($urandom_range(0, 3) == 0) dropped[own] = 1'b1;
            end
            drive_reqs();
            #1;
            ab = (t >= TIMEOUT - 1) && !hs && !rsp;
            chk("gnt", req_gnt, oh);
            chk("busy", busy, 1);
            chk("cmd_valid", m_cmd_valid, !accepted);
            chk("abort", m_abort, ab);
            chk("done_early", req_done, 0);
            if (!accepted) chk("cmd_word", {m_cmd_addr, m_cmd_rw, m_cmd_wdata}, {ea, erw, ew});
            if (hs) accepted = 1;
            if (rsp || ab) finished = 1;
            t++;
            step();
        end
        m_cmd_ready = 1'b0;
        m_rsp_valid = 1'($urandom);
        #1;
        chk("done", req_done, oh);
        chk("done_gnt", req_gnt, oh);
        chk("rdata", req_rdata, (ab || !erw) ? 8'h00 : rd);
        chk("nack", req_nack, ab ? 1'b0 : nk);
        chk("timeout", req_timeout, ab);
        chk("done_abort", m_abort, 0);
        chk("done_cmd_valid", m_cmd_valid, 0);
        pending[own] = 1'b0;
        dropped      = '0;
        rr_m         = (own + 1) % NREQ;
        step();
        m_rsp_valid = 1'($urandom);
        #1;
        chk("post_busy", busy, 0);
        chk("post_gnt", req_gnt, 0);
        chk("post_done", req_done, 0);
    endtask

    task automatic refill_random();
        for (int i = 0; i < NREQ; i++) begin
            if (!pending[i] && $urandom_range(0, 1) == 1) begin
                logic [6:0] a;
                case ($urandom_range(0, 3))
                    0: a = 7'h50;
                    1: a = 7'h51;
                    2: a = 7'h52;
                    default: a = 7'($urandom);
                endcase
                set_desc(i, a, 1'($urandom), 8'($urandom));
            end
        end
        xlate_en = 1'($urandom);
        xlate_to = 7'($urandom);
        if ($urandom_range(0, 2) == 0) xlate_from = 7'($urandom);
        else xlate_from = d_addr[$urandom_range(0, NREQ - 1)];
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            d_addr[i] = '0; d_rw[i] = 1'b0; d_wdata[i] = '0;
        end
        #1;
        chk("rst_gnt", req_gnt, 0);
        chk("rst_done", req_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cmd_valid", m_cmd_valid, 0);
        chk("rst_abort", m_abort, 0);
        chk("rst_cmd_word", {m_cmd_addr, m_cmd_rw, m_cmd_wdata}, 0);
        chk("rst_result", {req_rdata, req_nack, req_timeout}, 0);
        step();
        step();
        rst = 1'b0;

        set_desc(0, 7'h50, 1'b0, 8'hA5);
        run_txn(0, 1, 8'h77, 1'b0);

        xlate_en = 1'b1; xlate_from = 7'h50; xlate_to = 7'h52;
        set_desc(1, 7'h50, 1'b1, 8'h00);
        run_txn(0, 0, 8'h3C, 1'b0);

        xlate_en = 1'b0;
        for (int n = 0; n < 5; n++) begin
            for (int i = 0; i < NREQ; i++) set_desc(i, 7'(8'h20 + i), 1'b1, 8'($urandom));
            run_txn(0, 0, 8'($urandom), 1'b0);
        end
        pending = '0;
        set_desc(2, 7'h22, 1'b1, 8'h00);
        run_txn(0, 0, 8'h5A, 1'b0);

        set_desc(0, 7'h10, 1'b1, 8'h00); run_txn(0, 100, 8'h11, 1'b0);
        set_desc(0, 7'h10, 1'b0, 8'h33); run_txn(100, 0, 8'h11, 1'b0);
        set_desc(0, 7'h10, 1'b1, 8'h00); run_txn(TIMEOUT - 1, 5, 8'h22, 1'b0);
        set_desc(0, 7'h10, 1'b1, 8'h00); run_txn(0, TIMEOUT - 2, 8'h44, 1'b1);
        set_desc(0, 7'h10, 1'b1, 8'h00); run_txn(0, TIMEOUT - 3, 8'h66, 1'b0);
        set_desc(3, 7'h11, 1'b1, 8'h00); run_txn(2, 3, 8'h99, 1'b1);

        set_desc(1, 7'h31, 1'b0, 8'hC3);
        run_txn(0, 0, 8'h00, 1'b0);
        pending = '0;
        set_desc(3, 7'h33, 1'b1, 8'h00);
        drive_reqs();
        step();
        m_cmd_ready = 1'b1;
        step();
        m_cmd_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_gnt", req_gnt, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_abort", m_abort, 0);
        chk("midrst_outs", {req_done, m_cmd_valid, req_rdata, req_nack, req_timeout}, 0);
        chk("midrst_cmd_word", {m_cmd_addr, m_cmd_rw, m_cmd_wdata}, 0);
        step();
        rst  = 1'b0;
        rr_m = 0;
        set_desc(1, 7'h41, 1'b1, 8'h00);
        run_txn(1, 1, 8'hE7, 1'b0);

        for (int n = 0; n < 200; n++) begin
            int d1, d2;
            refill_random();
            d1 = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 20) : $urandom_range(0, 3);
            d2 = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 20) : $urandom_range(0, 3);
            run_txn(d1, d2, 8'($urandom), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
